// File: rtl/amp2_pkg.sv
// rtl/amp2_pkg.sv - shared state encoding and default timing constants for the PmodAMP2 source arbiter
package amp2_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_WAKE    = 3'd1,
        ST_ON_IDLE = 3'd2,
        ST_GRANTED = 3'd3,
        ST_GAP     = 3'd4
    } amp2_state_t;

    localparam int DEF_NUM_SRC     = 4;
    localparam int DEF_WAKE_CYCLES = 100000;
    localparam int DEF_GAP_CYCLES  = 1000;
    localparam int DEF_IDLE_CYCLES = 10000000;

    // Largest of three cycle counts; sizes the shared state counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/amp2_rr_picker.sv
// rtl/amp2_rr_picker.sv - combinational round-robin one-hot selector, search starts just past the pointer
module amp2_rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IW-1:0]      i_rr_ptr,
    output logic [NUM_SRC-1:0] o_winner,
    output logic [IW-1:0]      o_idx
);

    // Walk sources rr_ptr+1, rr_ptr+2, ... (mod NUM_SRC); the first requester wins.
    always_comb begin : pick
        int          j;
        logic        found;
        logic [IW-1:0] sel;
        o_winner = '0;
        o_idx    = '0;
        found    = 1'b0;
        j        = 0;
        sel      = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            j   = (int'(i_rr_ptr) + i) % NUM_SRC;
            sel = IW'(j);
            if (!found && i_req[sel]) begin
                found         = 1'b1;
                o_winner[sel] = 1'b1;
                o_idx         = sel;
            end
        end
    end

endmodule

// File: rtl/amp2_source_arbiter.sv
// rtl/amp2_source_arbiter.sv - PmodAMP2 shutdown sequencing and round-robin PWM source mux; AMP2_AUTO_SHUTDOWN_EN enables idle power-down
module amp2_source_arbiter
    import amp2_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] pwm_in,
    output logic [NUM_SRC-1:0] grant,
    output logic               audio_out,
    output logic               amp_shutdown_n,
    output logic               busy
);

    localparam int IW      = $clog2(NUM_SRC);
    localparam int CNT_MAX = max3(WAKE_CYCLES, GAP_CYCLES, IDLE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
`ifdef AMP2_AUTO_SHUTDOWN_EN
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
`endif
    // Pointer starts at the last source so source 0 wins the first tie.
    localparam logic [IW-1:0] RR_RESET  = IW'(NUM_SRC - 1);

    amp2_state_t        r_state;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_rr_ptr;
    logic [NUM_SRC-1:0] r_grant;
    logic               r_audio;
    logic               r_amp_on;
    logic               r_busy;

    logic [NUM_SRC-1:0] w_winner;
    logic [IW-1:0]      w_idx;
    logic               w_any_req;
    logic [CW-1:0]      w_cnt_inc;

    assign w_any_req = |req;
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

    amp2_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_idx    (w_idx)
    );

    // Amplifier power sequencing, arbitration and the registered audio mux in one FSM.
    // While GRANTED, r_rr_ptr doubles as the index of the current owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_OFF;
            r_cnt    <= '0;
            r_rr_ptr <= RR_RESET;
            r_grant  <= '0;
            r_audio  <= 1'b0;
            r_amp_on <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_grant  <= '0;
                    r_audio  <= 1'b0;
                    r_amp_on <= 1'b0;
                    if (w_any_req) begin
                        r_state  <= ST_WAKE;
                        r_cnt    <= '0;
                        r_amp_on <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // Requests may vanish here; the amplifier still finishes starting up.
                    if (r_cnt == WAKE_LAST) begin
                        r_state <= ST_ON_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_ON_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= ST_GRANTED;
                        r_cnt    <= '0;
                        r_grant  <= w_winner;
                        r_rr_ptr <= w_idx;
                        r_busy   <= 1'b1;
`ifdef AMP2_AUTO_SHUTDOWN_EN
                    end else if (r_cnt == IDLE_LAST) begin
                        r_state  <= ST_OFF;
                        r_cnt    <= '0;
                        r_amp_on <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
`endif
                    end
                end
                ST_GRANTED: begin
                    // No preemption: only the owner dropping its request ends the grant.
                    if (!req[r_rr_ptr]) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_grant <= '0;
                        r_audio <= 1'b0;
                    end else begin
                        r_audio <= pwm_in[r_rr_ptr];
                    end
                end
                ST_GAP: begin
                    // Forced silence between owners to keep the speaker from popping.
                    if (r_cnt == GAP_LAST) begin
                        r_state <= ST_ON_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state  <= ST_OFF;
                    r_cnt    <= '0;
                    r_grant  <= '0;
                    r_audio  <= 1'b0;
                    r_amp_on <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign grant          = r_grant;
    assign audio_out      = r_audio;
    assign amp_shutdown_n = r_amp_on;
    assign busy           = r_busy;

endmodule

// File: tb/tb_amp2_source_arbiter.sv
// tb/tb_amp2_source_arbiter.sv - directed scoreboard bench for amp2_source_arbiter (NUM_SRC=4, WAKE=8, GAP=4, IDLE=32)
module tb_amp2_source_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] pwm_in;
    logic [3:0] grant;
    logic       audio_out;
    logic       amp_shutdown_n;
    logic       busy;

    typedef struct packed {
        logic [3:0] g;
        logic       a;
        logic       s;
        logic       b;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_chk;
    int    n_fail;
    logic [5:0] pat;

    amp2_source_arbiter #(
        .NUM_SRC     (4),
        .WAKE_CYCLES (8),
        .GAP_CYCLES  (4),
        .IDLE_CYCLES (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .pwm_in         (pwm_in),
        .grant          (grant),
        .audio_out      (audio_out),
        .amp_shutdown_n (amp_shutdown_n),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string t, input logic [3:0] eg, input logic ea, input logic es, input logic eb);
        exp_t e;
        e.g = eg;
        e.a = ea;
        e.s = es;
        e.b = eb;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_chk++;
        assert (grant === e.g) else begin
            n_fail++;
            $error("FAIL %s grant observed=%b expected=%b", t, grant, e.g);
        end
        n_chk++;
        assert (audio_out === e.a) else begin
            n_fail++;
            $error("FAIL %s audio_out observed=%b expected=%b", t, audio_out, e.a);
        end
        n_chk++;
        assert (amp_shutdown_n === e.s) else begin
            n_fail++;
            $error("FAIL %s amp_shutdown_n observed=%b expected=%b", t, amp_shutdown_n, e.s);
        end
        n_chk++;
        assert (busy === e.b) else begin
            n_fail++;
            $error("FAIL %s busy observed=%b expected=%b", t, busy, e.b);
        end
    endtask

    // Called at a falling edge: drive inputs, expect the given outputs after the next rising edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] p, input string t,
                       input logic [3:0] eg, input logic ea, input logic es, input logic eb);
        req    = r;
        pwm_in = p;
        push_exp(t, eg, ea, es, eb);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic chk_now(input string t, input logic [3:0] eg, input logic ea, input logic es, input logic eb);
        push_exp(t, eg, ea, es, eb);
        check_out();
    endtask

    // OFF -> WAKE (8 cycles) -> ON_IDLE; r0 on the first cycle, rn afterwards.
    task automatic wake(input logic [3:0] r0, input logic [3:0] rn, input string t);
        cyc(r0, 4'b0000, t, 4'b0000, 1'b0, 1'b1, 1'b1);
        repeat (7) cyc(rn, 4'b0000, t, 4'b0000, 1'b0, 1'b1, 1'b1);
        cyc(rn, 4'b0000, t, 4'b0000, 1'b0, 1'b1, 1'b0);
    endtask

    // Owner drops: 4 GAP cycles then ON_IDLE, with r as the remaining requests.
    task automatic gap_seq(input logic [3:0] r, input string t);
        repeat (4) cyc(r, 4'b1111, t, 4'b0000, 1'b0, 1'b1, 1'b1);
        cyc(r, 4'b1111, t, 4'b0000, 1'b0, 1'b1, 1'b0);
    endtask

    // Starting right after ON_IDLE entry with no requests.
    task automatic idle_run(input string t);
`ifdef AMP2_AUTO_SHUTDOWN_EN
        repeat (31) cyc(4'b0000, 4'b0000, t, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, t, 4'b0000, 1'b0, 1'b0, 1'b0);
`else
        repeat (100) cyc(4'b0000, 4'b0000, t, 4'b0000, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        logic [31:0] rnd;
        logic        bit_v;
        logic [3:0]  p;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        pwm_in = 4'b0000;
        pat    = 6'b101101;
        repeat (3) @(negedge clk);
        chk_now("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(4'b0000, 4'b0000, "off_hold", 4'b0000, 1'b0, 1'b0, 1'b0);

        // 1: first request wakes the amp; grant lands 9 cycles after WAKE entry
        wake(4'b0001, 4'b0001, "t1_wake");
        cyc(4'b0001, 4'b0000, "t1_grant", 4'b0001, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bit_v = pat[i];
            p     = bit_v ? 4'b0001 : 4'b1110;
            cyc(4'b0001, p, "t1_audio", 4'b0001, bit_v, 1'b1, 1'b1);
        end

        // 2: rr_ptr=0, req=1010 -> source 1, then source 3 after the gap
        gap_seq(4'b0000, "t1_gap");
        cyc(4'b0000, 4'b0000, "t2_idle", 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(4'b1010, 4'b0000, "t2_grant", 4'b0010, 1'b0, 1'b1, 1'b1);
        cyc(4'b1010, 4'b0010, "t2_audio1", 4'b0010, 1'b1, 1'b1, 1'b1);
        cyc(4'b1010, 4'b1101, "t2_audio0", 4'b0010, 1'b0, 1'b1, 1'b1);
        gap_seq(4'b1000, "t2_gap");
        cyc(4'b1000, 4'b0000, "t2_next", 4'b1000, 1'b0, 1'b1, 1'b1);

        // 3: source 2 keeps the grant while others churn
        gap_seq(4'b0000, "t3_gap0");
        cyc(4'b0100, 4'b0000, "t3_grant", 4'b0100, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rnd   = $urandom;
            bit_v = rnd[8];
            cyc(4'b0100 | (rnd[3:0] & 4'b1011), {rnd[7], bit_v, rnd[5:4]}, "t3_hold",
                4'b0100, bit_v, 1'b1, 1'b1);
        end
        gap_seq(4'b0000, "t3_gap");

        // 4: idle timeout (or no timeout without the auto-shutdown build)
        idle_run("t4_idle");

        // 5: async reset mid-grant, then a full re-wake
`ifdef AMP2_AUTO_SHUTDOWN_EN
        wake(4'b1001, 4'b1001, "t5_wake");
`endif
        cyc(4'b1001, 4'b0000, "t5_grant", 4'b1000, 1'b0, 1'b1, 1'b1);
        cyc(4'b1001, 4'b1000, "t5_audio", 4'b1000, 1'b1, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1 chk_now("t5_async_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc(4'b0000, 4'b0000, "t5_off", 4'b0000, 1'b0, 1'b0, 1'b0);
        wake(4'b0100, 4'b0100, "t5_rewake");
        cyc(4'b0100, 4'b0000, "t5_grant2", 4'b0100, 1'b0, 1'b1, 1'b1);
        gap_seq(4'b0000, "t5_gap");

        // 6: request drops during WAKE; wake completes, no grant, idle runs normally
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(4'b0000, 4'b0000, "t6_off", 4'b0000, 1'b0, 1'b0, 1'b0);
        wake(4'b0001, 4'b0000, "t6_wake");
        idle_run("t6_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
